exu_shift_pipe: RTL

//  Two-stage pipelined shift execution unit in the RV64 EXU, between issue and writeback.
//  - Stage 1 (S1): registers the decoded shift op and its operands.
//  - The existing combinational shifter computes from the S1 registers.
//  - Stage 2 (S2): registers the result, sign-extended for *W ops.

---
 rtl/exu_shift_pipe_pkg.sv | 21 ++
 rtl/exu_shift_pipe_alu_shift.sv | 48 ++++
 rtl/exu_shift_pipe.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/exu_shift_pipe_pkg.sv
// Shared definitions for the pipelined shift execution unit.
//   XLEN        : datapath width (fixed at 64 for RV64)
//   shift_op_t  : one-hot shift op stored in S1 (OP_SLL/OP_SRL/OP_SRA, OP_NONE = no op bit)
//   sext32()    : sign-extends a 32-bit value to XLEN for *W results
package exu_shift_pipe_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned OP_W = 3;

    typedef logic [OP_W-1:0] shift_op_t;

    localparam shift_op_t OP_NONE = 3'b000;
    localparam shift_op_t OP_SLL  = 3'b001;
    localparam shift_op_t OP_SRL  = 3'b010;
    localparam shift_op_t OP_SRA  = 3'b100;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/exu_shift_pipe_alu_shift.sv
// Combinational shifter used as the datapath of exu_shift_pipe.
//   op_i     : one-hot shift op (OP_NONE yields 0)
//   word_i   : *W variant; count masked to 5 bits, only rs1[31:0] used
//   rs1_i    : value to shift
//   shamt_i  : 6-bit shift count
//   result_o : raw shift result (low 32 bits are the word result for *W ops)
module alu_shift
    import exu_shift_pipe_pkg::*;
(
    input  shift_op_t        op_i,
    input  logic             word_i,
    input  logic [XLEN-1:0]  rs1_i,
    input  logic [5:0]       shamt_i,
    output logic [XLEN-1:0]  result_o
);

    logic [5:0]      amt;
    logic [5:0]      right_amt;
    logic [XLEN-1:0] left_src;
    logic [XLEN-1:0] right_src;
    logic [XLEN-1:0] srl_res;
    logic [XLEN-1:0] fill_mask;
    logic [XLEN-1:0] sra_res;
    logic [XLEN-1:0] sll_res;

    always_comb begin
        amt       = word_i ? {1'b0, shamt_i[4:0]} : shamt_i;
        left_src  = word_i ? {32'b0, rs1_i[31:0]} : rs1_i;
        // Word right shifts run on the upper half so bit 63 carries the word's sign;
        // the extra 32 realigns the result into the low half. The 6-bit sum is intentional.
        right_src = word_i ? {rs1_i[31:0], 32'b0} : rs1_i;
        right_amt = word_i ? (amt + 6'd32) : amt;

        srl_res   = right_src >> right_amt;
        fill_mask = ~({XLEN{1'b1}} >> right_amt);
        sra_res   = srl_res | (right_src[XLEN-1] ? fill_mask : '0);
        sll_res   = left_src << amt;

        result_o = '0;
        unique case (op_i)
            OP_SLL:  result_o = sll_res;
            OP_SRL:  result_o = srl_res;
            OP_SRA:  result_o = sra_res;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/exu_shift_pipe.sv
// Two-stage pipelined shift unit between issue and writeback.
//   S1 registers the decoded op and operands; alu_shift computes from S1; S2 registers
//   the result (sign-extended for *W ops). Valid/ready on both sides; flush_i kills
//   everything in flight and blocks acceptance for that cycle.
//   clk, rst (async, active-high), flush_i
//   in_*  : issue-side handshake and operands (in_ready_o out)
//   out_* : writeback-side handshake, result and destination tag
module exu_shift_pipe
    import exu_shift_pipe_pkg::*;
#(
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             in_sra_i,
    input  logic             in_srl_i,
    input  logic             in_sll_i,
    input  logic             in_word_i,
    input  logic [XLEN-1:0]  in_rs1_i,
    input  logic [5:0]       in_shamt_i,
    input  logic [TAG_W-1:0] in_rd_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  out_result_o,
    output logic [TAG_W-1:0] out_rd_o
);

    logic             s1_valid_q, s1_valid_d;
    shift_op_t        s1_op_q, s1_op_d;
    logic             s1_word_q, s1_word_d;
    logic [XLEN-1:0]  s1_rs1_q, s1_rs1_d;
    logic [5:0]       s1_shamt_q, s1_shamt_d;
    logic [TAG_W-1:0] s1_rd_q, s1_rd_d;

    logic             s2_valid_q, s2_valid_d;
    logic [XLEN-1:0]  s2_result_q, s2_result_d;
    logic [TAG_W-1:0] s2_rd_q, s2_rd_d;

    logic             s1_ready;
    logic             s2_ready;
    logic             s1_load;
    logic             s2_load;
    logic [XLEN-1:0]  alu_result;
    shift_op_t        dec_op;

    alu_shift u_alu_shift (
        .op_i     (s1_op_q),
        .word_i   (s1_word_q),
        .rs1_i    (s1_rs1_q),
        .shamt_i  (s1_shamt_q),
        .result_o (alu_result)
    );

    always_comb begin
        s2_ready   = ~s2_valid_q | out_ready_i;
        s1_ready   = ~s1_valid_q | s2_ready;
        in_ready_o = s1_ready & ~flush_i;
        s1_load    = in_valid_i & in_ready_o;
        s2_load    = s1_valid_q & s2_ready & ~flush_i;

        // Priority sra > srl > sll; exactly one bit survives.
        if (in_sra_i) begin
            dec_op = OP_SRA;
        end else if (in_srl_i) begin
            dec_op = OP_SRL;
        end else if (in_sll_i) begin
            dec_op = OP_SLL;
        end else begin
            dec_op = OP_NONE;
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_word_d   = s1_word_q;
        s1_rs1_d    = s1_rs1_q;
        s1_shamt_d  = s1_shamt_q;
        s1_rd_d     = s1_rd_q;
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_rd_d     = s2_rd_q;

        if (flush_i) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (s1_ready) begin
                s1_valid_d = in_valid_i;
            end
            if (s2_ready) begin
                s2_valid_d = s1_valid_q;
            end
        end

        if (s1_load) begin
            s1_op_d    = dec_op;
            s1_word_d  = in_word_i;
            s1_rs1_d   = in_rs1_i;
            s1_shamt_d = in_shamt_i;
            s1_rd_d    = in_rd_i;
        end

        if (s2_load) begin
            s2_result_d = s1_word_q ? sext32(alu_result[31:0]) : alu_result;
            s2_rd_d     = s1_rd_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= OP_NONE;
            s1_word_q   <= 1'b0;
            s1_rs1_q    <= '0;
            s1_shamt_q  <= '0;
            s1_rd_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_rd_q     <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_word_q   <= s1_word_d;
            s1_rs1_q    <= s1_rs1_d;
            s1_shamt_q  <= s1_shamt_d;
            s1_rd_q     <= s1_rd_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_rd_q     <= s2_rd_d;
        end
    end

    assign out_valid_o  = s2_valid_q;
    assign out_result_o = s2_result_q;
    assign out_rd_o     = s2_rd_q;

endmodule
